reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, entry count; a power of two and at least 2.
REQ-002 SHALL have parameter PHYSICAL_REG_NUM_WIDTH, default `PHYSICAL_REG_NUM_WIDTH, physical register index width.
REQ-003 SHALL have parameter INST_ADDR_WIDTH, default `INST_ADDR_WIDTH, PC width.
REQ-004 SHALL have: clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have: alloc_valid  input  1  rename stage requests an entry this cycle.
REQ-007 SHALL have: alloc_ready  output  1  entry available (not full).
REQ-008 SHALL have: alloc_with_write  input  1  instruction writes a destination register.
REQ-009 SHALL have: alloc_old_phy_reg  input  PHYSICAL_REG_NUM_WIDTH  previous mapping of the destination, to be freed at commit.
REQ-010 SHALL have: alloc_pc  input  INST_ADDR_WIDTH  instruction PC.
REQ-011 SHALL have: alloc_tag  output  $clog2(ROB_DEPTH)  index of the entry granted this cycle (the tail).
REQ-012 SHALL have: complete_valid / complete_tag  input  1 / $clog2(ROB_DEPTH)  execution-finished notification.
REQ-013 SHALL have: flush  input  1  synchronous squash of all entries.
REQ-014 SHALL have: commit_valid, commit_with_write  output  1 each  registered commit pulse and write flag.
REQ-015 SHALL have: commited_wr_register  output  PHYSICAL_REG_NUM_WIDTH  physical register to free.
REQ-016 SHALL have: commit_pc  output  INST_ADDR_WIDTH  PC of the committed instruction.

Function
REQ-017 SHALL be a circular FIFO with head/tail pointers of $clog2(ROB_DEPTH)+1 bits; the MSB is a lap bit; empty when pointers are equal, full when only the lap bits differ.
REQ-018 SHALL drive alloc_ready = !full combinationally from current state; allocation is never allowed in the same cycle as a commit frees a slot while the ROB is full.
REQ-019 SHALL write the entry at the tail and increment the tail (wrapping) on a rising edge when alloc_valid && alloc_ready; the entry has valid=1 and done=0.
REQ-020 SHALL set done on the edge where complete_valid is high and the entry at complete_tag is valid; completion to an invalid entry is ignored.
REQ-021 SHALL pop the head when the head entry is valid and done; register commit_valid=1 with the entry's with_write, old_phy_reg and pc; at most one commit per cycle.
REQ-022 SHALL give commit_valid a one-cycle pulse, visible in the cycle after the edge at which done was set. An allocation and completion can occur in the same cycle.
REQ-023 SHALL hold commit_valid=0 when no commit occurs; the other commit outputs keep their last values.
REQ-024 SHALL force commited_wr_register to 0 when commit_with_write=0.
REQ-025 SHALL leave the count unchanged on simultaneous allocation and commit; both pointers advance.
REQ-026 SHALL give flush priority over alloc, complete and commit: clear all valid bits, zero both pointers, and drive commit_valid=0 on the next cycle.

Reset
REQ-027 SHALL, on reset, clear the pointers and all valid/done bits, and drive commit_valid=0, commit_with_write=0, commited_wr_register=0, commit_pc=0, alloc_ready=1 and alloc_tag=0.
REQ-028 SHALL discard all in-flight entries when reset is asserted mid-operation; no commit pulse is emitted for them.

Configuration
REQ-029 SHALL, with ROB_OCCUPANCY_EN defined, add output rob_count [$clog2(ROB_DEPTH):0] equal to tail minus head; it is 0 after reset or flush.
REQ-030 SHALL, without ROB_OCCUPANCY_EN, have no rob_count port and no occupancy logic.

Structure
REQ-031 SHALL take rob_entry_t (valid, done, with_write, old_phy_reg, pc) and ROB_DEPTH from the shared project package.
REQ-032 SHALL instantiate sub-module rob_ptr_counter (lap-bit wrapping pointer with increment enable and synchronous clear), once for the head and once for the tail.

Verification (ROB_DEPTH=4)
REQ-033 Allocate with_write=1, old=5, pc=0x100, then complete tag 0 -> commit_valid pulses for 1 cycle with commited_wr_register=5 and commit_pc=0x100.
REQ-034 Allocate 4 entries -> alloc_ready=0 and a 5th alloc_valid is ignored; commit one -> alloc_ready=1 next cycle and the next alloc_tag=0 (wrap-around).
REQ-035 Complete tags 2, 1, 0 in that order -> commits appear in order 0, 1, 2 on consecutive cycles.
REQ-036 Issue flush in the same cycle as alloc and complete -> ROB is empty, commit_valid=0, and the next alloc_tag=0.
REQ-037 Assert reset with 3 entries done -> no commit pulses, and all outputs take their reset values immediately.
REQ-038 Allocate an entry with with_write=0 and complete it -> commit_valid=1, commit_with_write=0, commited_wr_register=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared project package for the reorder buffer slice.
// Provides the default ROB depth and the rob_entry_t record held in each ROB slot.
// The project-wide width macros PHYSICAL_REG_NUM_WIDTH and INST_ADDR_WIDTH are
// given fallback values here, so that a standalone build of this slice is complete.
// Optional feature macro used by the top: ROB_OCCUPANCY_EN.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;

    typedef struct packed {
        logic                               valid;
        logic                               done;
        logic                               with_write;
        logic [`PHYSICAL_REG_NUM_WIDTH-1:0] old_phy_reg;
        logic [`INST_ADDR_WIDTH-1:0]        pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_ptr_counter.sv
// rob_ptr_counter: wrapping ROB pointer that carries a lap bit above the index.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, clears the pointer
//   clear  - synchronous clear, has priority over inc
//   inc    - advance the pointer by one
//   ptr    - current pointer, MSB is the lap bit
// The ROB depth is a power of two, so natural binary overflow of the full
// pointer wraps the index and toggles the lap bit at the same time.
module rob_ptr_counter #(
    parameter int PTR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [PTR_WIDTH-1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit queue for renamed instructions.
// Ports:
//   clk, reset                 - clock (rising edge), asynchronous active-high reset
//   alloc_valid / alloc_ready  - rename requests a slot / a slot is free (not full)
//   alloc_with_write, alloc_old_phy_reg, alloc_pc - payload stored in the new slot
//   alloc_tag                  - slot index granted this cycle (current tail)
//   complete_valid / complete_tag - execution finished for the slot at complete_tag
//   flush                      - synchronous squash of every slot
//   commit_valid, commit_with_write, commited_wr_register, commit_pc
//                              - registered one-cycle commit pulse and its payload
//   rob_count                  - occupancy, only present with ROB_OCCUPANCY_EN defined
// A completion aimed at the current head commits on the same edge that records it,
// so the commit pulse is visible in the cycle right after that completion edge.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH              = reorder_buffer_pkg::ROB_DEPTH,
    parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
    parameter int INST_ADDR_WIDTH        = `INST_ADDR_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic                              alloc_with_write,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_old_phy_reg,
    input  logic [INST_ADDR_WIDTH-1:0]        alloc_pc,
    output logic [$clog2(ROB_DEPTH)-1:0]      alloc_tag,
    input  logic                              complete_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0]      complete_tag,
    input  logic                              flush,
    output logic                              commit_valid,
    output logic                              commit_with_write,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic [INST_ADDR_WIDTH-1:0]        commit_pc
`ifdef ROB_OCCUPANCY_EN
    ,
    output logic [$clog2(ROB_DEPTH):0]        rob_count
`endif
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    rob_entry_t             entries [ROB_DEPTH];
    logic       [PTR_W-1:0] head_ptr;
    logic       [PTR_W-1:0] tail_ptr;
    logic       [IDX_W-1:0] head_idx;
    logic       [IDX_W-1:0] tail_idx;
    logic                   full;
    logic                   do_alloc;
    logic                   do_commit;
    rob_entry_t             head_entry;

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];

    // Same index on a different lap means every slot is occupied.
    assign full = (head_ptr[IDX_W] != tail_ptr[IDX_W]) && (head_idx == tail_idx);

    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign head_entry  = entries[head_idx];

    assign do_alloc  = alloc_valid && !full && !flush;
    // Head commits if already done or being completed right now.
    assign do_commit = !flush && head_entry.valid &&
                       (head_entry.done || (complete_valid && complete_tag == head_idx));

    rob_ptr_counter #(.PTR_WIDTH(PTR_W)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (do_commit),
        .ptr   (head_ptr)
    );

    rob_ptr_counter #(.PTR_WIDTH(PTR_W)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (do_alloc),
        .ptr   (tail_ptr)
    );

    // Slot storage and registered commit outputs. Allocation can never hit the
    // head slot while it is valid (that would need a full ROB), and the commit
    // clear is written last so it wins over a same-edge completion of the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
            commit_valid         <= 1'b0;
            commit_with_write    <= 1'b0;
            commited_wr_register <= '0;
            commit_pc            <= '0;
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
            commit_valid <= 1'b0;
        end else begin
            if (complete_valid && entries[complete_tag].valid) begin
                entries[complete_tag].done <= 1'b1;
            end
            if (do_alloc) begin
                entries[tail_idx] <= '{valid:       1'b1,
                                       done:        1'b0,
                                       with_write:  alloc_with_write,
                                       old_phy_reg: alloc_old_phy_reg,
                                       pc:          alloc_pc};
            end
            commit_valid <= do_commit;
            if (do_commit) begin
                entries[head_idx].valid <= 1'b0;
                entries[head_idx].done  <= 1'b0;
                commit_with_write       <= head_entry.with_write;
                commited_wr_register    <= head_entry.with_write ? head_entry.old_phy_reg : '0;
                commit_pc               <= head_entry.pc;
            end
        end
    end

`ifdef ROB_OCCUPANCY_EN
    assign rob_count = tail_ptr - head_ptr;
`endif

endmodule
